pixel_write_arbiter: RTL
========================

# pixel_write_arbiter

Shares the single VGA adapter pixel-write port between the three drawing sources of the game: background painter, fruit sprite datapath and mouse cursor. Replaces the fixed priority mux in the top level with a request/grant handshake and burst locking, so a sprite or screen fill is never interleaved with another source. It adds cursor starvation protection, transparent-pixel suppression and off-screen clipping. It sits between the datapaths/control FSM and the VGA adapter inputs.

## Interface
- STARVE_LIMIT, 1024: cycles a pending cursor request may wait before it wins arbitration.
- SCREEN_W, 160: visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120: visible height; pixels with y >= SCREEN_H are clipped.
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- bg_req, fr_req, cur_req  in  1 each  source has a pixel valid on its x/y/colour.
- bg_last, fr_last, cur_last  in  1 each  current pixel is the final one of the burst.
- bg_x, fr_x, cur_x  in  8 each  pixel x.
- bg_y, fr_y, cur_y  in  7 each  pixel y.
- bg_colour, fr_colour, cur_colour  in  24 each  pixel RGB888.
- bg_gnt, fr_gnt, cur_gnt  out  1 each  source owns the port (registered, one-hot or zero).
- bg_ack, fr_ack, cur_ack  out  1 each  pixel accepted this cycle (gnt & req, combinational).
- x_out  out  8  to VGA adapter.
- y_out  out  7  to VGA adapter.
- colour_out  out  24  to VGA adapter.
- plot  out  1  write enable to VGA adapter.
- busy  out  1  a grant is active.

## Operation
- States: IDLE, GNT_BG, GNT_FR, GNT_CUR. Reset enters IDLE.
- IDLE: when any req is high, choose the winner and move to its GNT state next cycle. If cur_wait == STARVE_LIMIT and cur_req is high, the cursor wins. Otherwise priority is bg > fr > cur. No pixel is accepted in IDLE.
- GNT_x: ack_x = req_x. Each acked pixel is registered to the outputs.
- GNT_x exit: return to IDLE after an acked pixel with last_x = 1, or on any cycle where req_x = 0 (burst abort). Other sources' req are ignored while in GNT_x.
- plot = 1 for an acked pixel unless it is clipped (x >= SCREEN_W or y >= SCREEN_H) or is a fruit pixel with colour 0 (transparent). Suppressed pixels still update x_out/y_out/colour_out.
- Starvation counter cur_wait:
  - Increments each cycle cur_req = 1 and cur_gnt = 0.
  - Saturates at STARVE_LIMIT.
  - Clears when entering GNT_CUR.
  - Holds when cur_req = 0.
- Source contract: a source must hold x/y/colour/last stable while req is high and ack is low, and must change them the cycle after an ack.

## Timing
- Reset values: all gnt 0, busy 0, plot 0, x_out 0, y_out 0, colour_out 0, cur_wait 0, state IDLE.
- Arbitration: req seen in IDLE at cycle N, gnt at N+1, first ack at N+1.
- Output latency: a pixel acked at cycle M appears on x_out/y_out/colour_out/plot at M+1.
- plot is 0 in any cycle following a cycle with no ack.
- Burst end: last acked at M gives IDLE at M+1 and a new grant at M+2. There is exactly one bubble cycle between bursts.
- Maximum throughput: one pixel per cycle within a burst.
- A single-pixel burst (req with last at grant) occupies 2 cycles of port time.
- Simultaneous requests in IDLE are resolved by starvation first, then priority.
- A req that drops in the same cycle as the grant arrives aborts the burst with zero pixels accepted.
- Reset mid-burst returns to the reset values on the next edge. No partial output is held.

## Structure
- Shared package pixel_arb_pkg holds:
  - state enum arb_state_t;
  - SCREEN_W, SCREEN_H;
  - TRANSPARENT_COLOUR = 24'h000000;
  - source index constants SRC_BG, SRC_FR, SRC_CUR.
- One natural sub-module, starve_counter: the saturating wait counter with inc, clr and saturated outputs, parameterised by LIMIT.
- The output register and mux stay in the top arbiter.

## Test plan
- Only bg_req, 5-pixel burst with last on pixel 4 at (0,0)..(4,0), colour FFFFFF:
  - bg_gnt one cycle after the request;
  - 5 consecutive plot pulses, each one cycle after its ack;
  - IDLE on the cycle after the last ack.
- bg_req and fr_req rise together: bg granted first. fr is granted exactly 2 cycles after bg's last ack, and no fr pixel appears during the bg burst.
- Fruit pixels with colours 0, 00FF00, 0 are acked; plot sequence is 0,1,0 while x_out still steps through all three positions.
- Cursor pixel at x=200, y=50, and a bg pixel at x=159, y=120: both acked with plot 0. A pixel at (159,119) gives plot 1.
- STARVE_LIMIT=8, continuous back-to-back fr bursts with cur_req held high: cur_gnt asserts at the first IDLE after cur_wait reaches 8, and cur_wait reads 0 after the grant.
- resetn low for 1 cycle mid-fr-burst: next cycle all gnt 0, plot 0, outputs 0. With fr_req still high, fr is re-granted 1 cycle after resetn returns high.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the pixel-write arbiter: FSM states,
// screen geometry, transparency key and source indices.
package pixel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_BG  = 2'd1,
    GNT_FR  = 2'd2,
    GNT_CUR = 2'd3
  } arb_state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [23:0] TRANSPARENT_COLOUR = 24'h000000;

  localparam int SRC_BG  = 0;
  localparam int SRC_FR  = 1;
  localparam int SRC_CUR = 2;
  localparam int NUM_SRC = 3;

  localparam int STARVE_LIMIT_DEFAULT = 1024;

  // One-hot grant vector owned by each state; IDLE owns nothing.
  function automatic logic [NUM_SRC-1:0] gnt_of(arb_state_t s);
    logic [NUM_SRC-1:0] g;
    g = '0;
    case (s)
      GNT_BG:  g[SRC_BG]  = 1'b1;
      GNT_FR:  g[SRC_FR]  = 1'b1;
      GNT_CUR: g[SRC_CUR] = 1'b1;
      default: g = '0;
    endcase
    return g;
  endfunction

  function automatic logic on_screen(logic [7:0] x, logic [6:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_starve_counter.sv
// Saturating wait counter for a pending requester; clear wins over increment.
module starve_counter #(
  parameter int LIMIT = 1024,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         saturated_o
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign saturated_o = (count_q == LIM);

endmodule

// File: rtl/pixel_write_arbiter.sv
// Request/grant arbiter with burst locking in front of the VGA pixel-write
// port; adds cursor starvation protection, transparency and clipping.
//
// Handshake: a source raises req with x/y/colour/last stable; the pixel is
// transferred in any cycle where gnt & req (ack). After an ack the source must
// present its next pixel (or drop req) on the following cycle.
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              bg_req_i,
  input  logic              fr_req_i,
  input  logic              cur_req_i,
  input  logic              bg_last_i,
  input  logic              fr_last_i,
  input  logic              cur_last_i,
  input  logic [7:0]        bg_x_i,
  input  logic [7:0]        fr_x_i,
  input  logic [7:0]        cur_x_i,
  input  logic [6:0]        bg_y_i,
  input  logic [6:0]        fr_y_i,
  input  logic [6:0]        cur_y_i,
  input  logic [23:0]       bg_colour_i,
  input  logic [23:0]       fr_colour_i,
  input  logic [23:0]       cur_colour_i,
  output logic              bg_gnt_o,
  output logic              fr_gnt_o,
  output logic              cur_gnt_o,
  output logic              bg_ack_o,
  output logic              fr_ack_o,
  output logic              cur_ack_o,
  output logic [7:0]        x_out_o,
  output logic [6:0]        y_out_o,
  output logic [23:0]       colour_out_o,
  output logic              plot_o,
  output logic              busy_o,
  output arb_state_t        state_o,
  output logic [WAIT_W-1:0] cur_wait_o
);

  arb_state_t         state_q;
  arb_state_t         win_state;
  logic [NUM_SRC-1:0] gnt_q;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ack;
  logic               end_burst;
  logic               cur_sat;
  logic               cur_inc;
  logic               cur_clr;

  assign req[SRC_BG]  = bg_req_i;
  assign req[SRC_FR]  = fr_req_i;
  assign req[SRC_CUR] = cur_req_i;
  assign ack          = gnt_q & req;

  // A starved cursor beats the fixed bg > fr > cur priority.
  always_comb begin
    win_state = IDLE;
    if (cur_sat && cur_req_i) begin
      win_state = GNT_CUR;
    end else if (bg_req_i) begin
      win_state = GNT_BG;
    end else if (fr_req_i) begin
      win_state = GNT_FR;
    end else if (cur_req_i) begin
      win_state = GNT_CUR;
    end
  end

  // Owner leaves on its last pixel or as soon as it drops req.
  always_comb begin
    end_burst = 1'b0;
    case (state_q)
      GNT_BG:  end_burst = !bg_req_i  || bg_last_i;
      GNT_FR:  end_burst = !fr_req_i  || fr_last_i;
      GNT_CUR: end_burst = !cur_req_i || cur_last_i;
      default: end_burst = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_state != IDLE) begin
            state_q <= win_state;
            gnt_q   <= gnt_of(win_state);
          end
        end
        default: begin
          if (end_burst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign cur_inc = cur_req_i && !gnt_q[SRC_CUR];
  assign cur_clr = (state_q == IDLE) && (win_state == GNT_CUR);

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_cur_wait (
    .clock      (clock),
    .resetn     (resetn),
    .inc_i      (cur_inc),
    .clr_i      (cur_clr),
    .count_o    (cur_wait_o),
    .saturated_o(cur_sat)
  );

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [23:0] sel_colour;
  logic        sel_is_fr;
  logic        pix_ok;
  logic        plot_d;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [23:0] colour_q;
  logic        plot_q;

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    sel_is_fr  = 1'b0;
    case (state_q)
      GNT_BG: begin
        sel_x      = bg_x_i;
        sel_y      = bg_y_i;
        sel_colour = bg_colour_i;
      end
      GNT_FR: begin
        sel_x      = fr_x_i;
        sel_y      = fr_y_i;
        sel_colour = fr_colour_i;
        sel_is_fr  = 1'b1;
      end
      GNT_CUR: begin
        sel_x      = cur_x_i;
        sel_y      = cur_y_i;
        sel_colour = cur_colour_i;
      end
      default: begin
        sel_is_fr = 1'b0;
      end
    endcase
  end

  assign pix_ok = |ack;
  // Clipped and transparent fruit pixels still move the output registers.
  assign plot_d = pix_ok && on_screen(sel_x, sel_y) &&
                  !(sel_is_fr && (sel_colour == TRANSPARENT_COLOUR));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= plot_d;
      if (pix_ok) begin
        x_q      <= sel_x;
        y_q      <= sel_y;
        colour_q <= sel_colour;
      end
    end
  end

  assign bg_gnt_o     = gnt_q[SRC_BG];
  assign fr_gnt_o     = gnt_q[SRC_FR];
  assign cur_gnt_o    = gnt_q[SRC_CUR];
  assign bg_ack_o     = ack[SRC_BG];
  assign fr_ack_o     = ack[SRC_FR];
  assign cur_ack_o    = ack[SRC_CUR];
  assign x_out_o      = x_q;
  assign y_out_o      = y_q;
  assign colour_out_o = colour_q;
  assign plot_o       = plot_q;
  assign busy_o       = |gnt_q;
  assign state_o      = state_q;

endmodule
